// File: rtl/sys_pkg.sv
// Shared types and defaults for the TX response queue.
// FSM state encoding plus default sizing constants.
package sys_pkg;

    localparam int DEF_DATA_WIDTH   = 8;
    localparam int DEF_DEPTH        = 8;
    localparam int DEF_BUSY_TIMEOUT = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_HI = 2'd1,
        WAIT_LO = 2'd2
    } tx_state_t;

endpackage

// File: rtl/tx_resp_queue_if.sv
// Response-in / byte-out bundle of the TX response queue.
// master drives pushes and Busy; slave is the queue itself.
interface tx_resp_queue_if #(
    parameter int DATA_WIDTH = sys_pkg::DEF_DATA_WIDTH
);

    logic [2*DATA_WIDTH-1:0] IN_DATA;
    logic                    IN_WIDE;
    logic                    IN_VLD;
    logic                    IN_RDY;
    logic                    Busy;
    logic [DATA_WIDTH-1:0]   TX_P_DATA;
    logic                    TX_D_VLD;
    logic                    ERR_CLR;
    logic                    OVF_ERR;
    logic                    TMO_ERR;

    modport master (
        output IN_DATA, IN_WIDE, IN_VLD, Busy, ERR_CLR,
        input  IN_RDY, TX_P_DATA, TX_D_VLD, OVF_ERR, TMO_ERR
    );

    modport slave (
        input  IN_DATA, IN_WIDE, IN_VLD, Busy, ERR_CLR,
        output IN_RDY, TX_P_DATA, TX_D_VLD, OVF_ERR, TMO_ERR
    );

endinterface

// File: rtl/byte_fifo.sv
// Byte FIFO with a 1-or-2 byte write port and a 1-byte pop.
// Read data is the head byte, valid whenever count is non-zero.
module byte_fifo
    import sys_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    localparam int PTR_W     = $clog2(DEPTH),
    localparam int CNT_W     = $clog2(DEPTH) + 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_wr_en,
    input  logic                    i_wr_wide,
    input  logic [2*DATA_WIDTH-1:0] i_wr_data,
    input  logic                    i_rd_en,
    output logic [DATA_WIDTH-1:0]   o_rd_data,
    output logic [CNT_W-1:0]        o_count
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;

    logic [PTR_W-1:0]      w_wr_ptr_p1;
    logic [CNT_W-1:0]      w_push_n;
    logic [CNT_W-1:0]      w_pop_n;

    assign w_wr_ptr_p1 = r_wr_ptr + PTR_W'(1);
    assign w_push_n    = !i_wr_en  ? '0 :
                         i_wr_wide ? CNT_W'(2) : CNT_W'(1);
    assign w_pop_n     = i_rd_en ? CNT_W'(1) : '0;

    // Storage write: low byte at wr_ptr, high byte right after it
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[r_wr_ptr] <= i_wr_data[DATA_WIDTH-1:0];
            if (i_wr_wide) begin
                r_mem[w_wr_ptr_p1] <= i_wr_data[2*DATA_WIDTH-1:DATA_WIDTH];
            end
        end
    end

    // Pointers wrap naturally; count uses pre-update value
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_wr_en) begin
                r_wr_ptr <= r_wr_ptr + (i_wr_wide ? PTR_W'(2) : PTR_W'(1));
            end
            if (i_rd_en) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= r_count + w_push_n - w_pop_n;
        end
    end

    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_count   = r_count;

endmodule

// File: rtl/tx_resp_queue.sv
// Byte-serialising response queue paced by the UART Busy handshake.
// One strobe per byte; each launch waits for Busy to rise then fall.
module tx_resp_queue
    import sys_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int DEPTH        = DEF_DEPTH,
    parameter int BUSY_TIMEOUT = DEF_BUSY_TIMEOUT
) (
    input  logic            CLK,
    input  logic            RST,
    tx_resp_queue_if.slave  bus
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int TMR_W = $clog2(BUSY_TIMEOUT);

    localparam logic [CNT_W-1:0] RDY_MAX  = CNT_W'(DEPTH - 2);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(BUSY_TIMEOUT - 1);

    tx_state_t             r_state;
    logic [TMR_W-1:0]      r_timer;
    logic [DATA_WIDTH-1:0] r_tx_data;
    logic                  r_tx_vld;
    logic                  r_ovf_err;
    logic                  r_tmo_err;

    tx_state_t             w_state_nxt;
    logic [TMR_W-1:0]      w_timer_nxt;
    logic                  w_pop;
    logic                  w_tmo_evt;
    logic                  w_push;
    logic                  w_ovf_evt;
    logic                  w_rdy;
    logic [CNT_W-1:0]      w_count;
    logic [DATA_WIDTH-1:0] w_rd_data;

    assign w_rdy     = (w_count <= RDY_MAX);
    assign w_push    = bus.IN_VLD & w_rdy;
    assign w_ovf_evt = bus.IN_VLD & ~w_rdy;

    byte_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .i_clk      (CLK),
        .i_rst      (RST),
        .i_wr_en    (w_push),
        .i_wr_wide  (bus.IN_WIDE),
        .i_wr_data  (bus.IN_DATA),
        .i_rd_en    (w_pop),
        .o_rd_data  (w_rd_data),
        .o_count    (w_count)
    );

    // Next-state: launch from IDLE, then see Busy rise and fall
    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_pop       = 1'b0;
        w_tmo_evt   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_count != '0 && !bus.Busy) begin
                    w_pop       = 1'b1;
                    w_timer_nxt = '0;
                    w_state_nxt = WAIT_HI;
                end
            end
            WAIT_HI: begin
                if (bus.Busy) begin
                    w_state_nxt = WAIT_LO;
                end else if (r_timer == TMR_LAST) begin
                    w_tmo_evt   = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_timer_nxt = r_timer + TMR_W'(1);
                end
            end
            WAIT_LO: begin
                if (!bus.Busy) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State, timer and registered launch outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= IDLE;
            r_timer   <= '0;
            r_tx_data <= '0;
            r_tx_vld  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_timer  <= w_timer_nxt;
            r_tx_vld <= w_pop;
            if (w_pop) begin
                r_tx_data <= w_rd_data;
            end
        end
    end

    // Sticky error flags; a new event beats a clear
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_ovf_err <= 1'b0;
            r_tmo_err <= 1'b0;
        end else begin
            if (w_ovf_evt) begin
                r_ovf_err <= 1'b1;
            end else if (bus.ERR_CLR) begin
                r_ovf_err <= 1'b0;
            end
            if (w_tmo_evt) begin
                r_tmo_err <= 1'b1;
            end else if (bus.ERR_CLR) begin
                r_tmo_err <= 1'b0;
            end
        end
    end

    assign bus.IN_RDY    = w_rdy;
    assign bus.TX_P_DATA = r_tx_data;
    assign bus.TX_D_VLD  = r_tx_vld;
    assign bus.OVF_ERR   = r_ovf_err;
    assign bus.TMO_ERR   = r_tmo_err;

endmodule
